nems_xbar_cfg_seq: RTL
======================

# nems_xbar_cfg_seq

Sequencer that programs the NEMS relay crossbar of one `clb_tile` through its `cfgrows`/`cfgcols` half-select lines. It erases every relay, then loads one 30-bit row pattern per column from an upstream valid/ready stream. Each column pattern is applied as a timed pulse followed by a settle gap, so relays latch hysteretically. It sits between the chip configuration loader and the tile's row/column drivers, on the same `cfg_clk` as the SRAM/scan configuration path.

## Interface
Parameters:
- `NROWS`, 30, crossbar row lines
- `NCOLS`, 29, crossbar column lines
- `ERASE_CYCLES`, 64, erase pulse width; must be ≥1
- `PULSE_CYCLES`, 16, per-column program pulse width; must be ≥1
- `GAP_CYCLES`, 4, settle gap after every pulse; must be ≥1

Ports:
- `cfg_clk`  in  1  configuration clock; single clock domain
- `cfg_rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin full erase+program sequence; sampled only in IDLE
- `abort`  in  1  terminate the sequence; sampled in any non-IDLE state
- `row_valid`  in  1  row pattern available
- `row_data`  in  NROWS  row pattern for the current column; bit r drives `cfgrows[r]`
- `row_ready`  out  1  sequencer accepts `row_data` this cycle
- `cfgrows`  out  NROWS  to tile `cfgrows`
- `cfgcols`  out  NCOLS  to tile `cfgcols`
- `col_idx`  out  $clog2(NCOLS)  column currently being loaded or pulsed
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the full sequence completes

## Operation
- States: IDLE, ERASE, EGAP, LOAD, PULSE, GAP.
- IDLE: all outputs 0. If `start`=1, go to ERASE, `col_idx`←0, tick counter←ERASE_CYCLES-1.
- ERASE: `cfgcols`=all-ones, `cfgrows`=0. Lasts exactly ERASE_CYCLES cycles, then EGAP.
- EGAP and GAP: `cfgcols`=0, `cfgrows`=0. Each lasts exactly GAP_CYCLES cycles.
  - EGAP goes to LOAD.
  - GAP with `col_idx`<NCOLS-1 increments `col_idx` and goes to LOAD.
  - GAP with `col_idx`=NCOLS-1 goes to IDLE and pulses `done`.
- LOAD: `row_ready`=1 and drive lines are 0. Stays in LOAD until `row_valid`=1, capturing `row_data` into the pattern register on that edge, then goes to PULSE. There is no timeout.
- PULSE: `cfgcols`=one-hot(`col_idx`), `cfgrows`=captured pattern. Lasts exactly PULSE_CYCLES cycles, then GAP.
- `row_ready` is high only in LOAD. `row_data` is ignored at all other times.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE; all drive lines are 0 from the next cycle.
  - No `done` pulse; a pending `row_ready` handshake in the same cycle is discarded.
  - `abort` takes priority over every other transition.
- `start` while busy is ignored. `start` and `abort` together in IDLE: start wins, because `abort` is ignored in IDLE.
- `cfgcols` never has more than one bit set, except in ERASE. `cfgcols` and `cfgrows` are never nonzero in the same cycle except in PULSE.
- `cfg_rst_n`=0 at any time: state→IDLE, all outputs→0 immediately (asynchronous), counter and `col_idx`→0.

## Timing
- All outputs are registered and change only on `cfg_clk` rising edge, except under asynchronous reset.
- `start` sampled at edge 0 → ERASE outputs visible in cycle 1.
- Defaults (E=64, P=16, G=4), `row_valid` held high:
  - ERASE: cycles 1–64; EGAP: 65–68.
  - Column k: LOAD at 69+21k, PULSE at 70+21k..85+21k, GAP at 86+21k..89+21k.
  - Column 28: LOAD 657, PULSE 658–673, GAP 674–677.
  - `done`=1 and `busy`=0 in cycle 678.
- Each cycle `row_valid` is low in LOAD adds exactly one cycle to the schedule.
- Per-column period is 1+P+G cycles minimum; whole sequence is 1+E+G+NCOLS·(1+P+G) cycles.

## Structure
- Package `nems_cfg_pkg`: state enum, default parameter constants, counter-width function.
- Sub-module `cfg_tick_cnt`: loadable down-counter with terminal-count flag. Width is $clog2 of max(ERASE_CYCLES, PULSE_CYCLES, GAP_CYCLES). It is reused for all timed states.
- Elaboration-time check rejects any of ERASE_CYCLES, PULSE_CYCLES or GAP_CYCLES below 1.

## Test plan
- Full run, defaults, `row_valid`=1, `row_data`=col index replicated:
  - Expect ERASE 64 cycles with `cfgcols`=29'h1FFFFFFF.
  - Expect column k one-hot with the matching pattern for exactly 16 cycles.
  - Expect `done` in cycle 678 and 29 handshakes.
- Backpressure: drop `row_valid` for 3 cycles at column 5 → that LOAD lasts 4 cycles, `done` in cycle 681, and no line is driven during the stall.
- Abort in PULSE of column 10 → next cycle all lines 0, `busy`=0, no `done`. A following `start` restarts from ERASE at column 0.
- Async reset asserted mid-GAP, between clock edges → outputs 0 before the next edge. After release, IDLE ignores `row_valid` and `row_ready` stays 0.
- `start` pulsed during PULSE, and `start`+`abort` together in IDLE → the first is ignored; the second begins ERASE next cycle.
- Parameters E=1, P=1, G=1, NCOLS=3 → sequence length is 1+1+1+3·3=12 cycles, checking the counter terminal-count edge cases.

Source files
------------

// File: rtl/nems_cfg_pkg.sv
// Shared types and defaults for the NEMS crossbar configuration sequencer.
package nems_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERASE = 3'd1,
        ST_EGAP  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_PULSE = 3'd4,
        ST_GAP   = 3'd5
    } seq_state_t;

    localparam int DEF_NROWS        = 30;
    localparam int DEF_NCOLS        = 29;
    localparam int DEF_ERASE_CYCLES = 64;
    localparam int DEF_PULSE_CYCLES = 16;
    localparam int DEF_GAP_CYCLES   = 4;

    // Counter holds at most max-1, so $clog2(max) bits suffice; floor at one bit.
    function automatic int tick_width(input int e, input int p, input int g);
        int m;
        m = e;
        if (p > m) m = p;
        if (g > m) m = g;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cfg_tick_cnt.sv
// Loadable down-counter with terminal-count flag, shared by every timed state.
module cfg_tick_cnt #(
    parameter int W = 6
) (
    input  logic         cfg_clk,
    input  logic         cfg_rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/nems_xbar_cfg_seq.sv
// Erase-then-program sequencer for one clb_tile NEMS relay crossbar.
// state    | meaning
// IDLE     | quiescent, waiting for start
// ERASE    | all columns half-selected, rows low: resets every relay
// EGAP     | settle after erase
// LOAD     | waiting for the next column's row pattern
// PULSE    | column one-hot with captured row pattern
// GAP      | settle after a column pulse
module nems_xbar_cfg_seq
    import nems_cfg_pkg::*;
#(
    parameter int NROWS        = DEF_NROWS,
    parameter int NCOLS        = DEF_NCOLS,
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                     cfg_clk,
    input  logic                     cfg_rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     row_valid,
    input  logic [NROWS-1:0]         row_data,
    output logic                     row_ready,
    output logic [NROWS-1:0]         cfgrows,
    output logic [NCOLS-1:0]         cfgcols,
    output logic [$clog2(NCOLS)-1:0] col_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(NCOLS);
    localparam int TW = tick_width(ERASE_CYCLES, PULSE_CYCLES, GAP_CYCLES);

    localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);
    localparam logic [TW-1:0] E_LD     = TW'(ERASE_CYCLES - 1);
    localparam logic [TW-1:0] P_LD     = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] G_LD     = TW'(GAP_CYCLES - 1);

    if (ERASE_CYCLES < 1 || PULSE_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_timing
        $error("nems_xbar_cfg_seq: ERASE/PULSE/GAP cycle counts must all be >= 1");
    end

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    col_d;
    logic [NROWS-1:0] pat_q, pat_d;
    logic             tick_load, tick_tc;
    logic [TW-1:0]    tick_val;
    logic             done_d, row_ready_d, busy_d;
    logic [NROWS-1:0] cfgrows_d;
    logic [NCOLS-1:0] cfgcols_d;

    cfg_tick_cnt #(.W(TW)) u_tick (
        .cfg_clk   (cfg_clk),
        .cfg_rst_n (cfg_rst_n),
        .load      (tick_load),
        .load_val  (tick_val),
        .tc        (tick_tc)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_idx;
        pat_d     = pat_q;
        tick_load = 1'b0;
        tick_val  = '0;
        done_d    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d   = ST_ERASE;
                col_d     = '0;
                tick_load = 1'b1;
                tick_val  = E_LD;
            end
        end else if (abort) begin
            state_d = ST_IDLE;
            col_d   = '0;
        end else begin
            case (state_q)
                ST_ERASE: if (tick_tc) begin
                    state_d   = ST_EGAP;
                    tick_load = 1'b1;
                    tick_val  = G_LD;
                end
                ST_EGAP: if (tick_tc) state_d = ST_LOAD;
                ST_LOAD: if (row_valid) begin
                    pat_d     = row_data;
                    state_d   = ST_PULSE;
                    tick_load = 1'b1;
                    tick_val  = P_LD;
                end
                ST_PULSE: if (tick_tc) begin
                    state_d   = ST_GAP;
                    tick_load = 1'b1;
                    tick_val  = G_LD;
                end
                ST_GAP: if (tick_tc) begin
                    if (col_idx == LAST_COL) begin
                        state_d = ST_IDLE;
                        col_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        col_d   = col_idx + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Drive lines are decoded from the next state so every output is a flop.
    always_comb begin
        cfgrows_d   = '0;
        cfgcols_d   = '0;
        row_ready_d = (state_d == ST_LOAD);
        busy_d      = (state_d != ST_IDLE);
        if (state_d == ST_ERASE) begin
            cfgcols_d = '1;
        end else if (state_d == ST_PULSE) begin
            cfgcols_d = NCOLS'(1) << col_d;
            cfgrows_d = pat_d;
        end
    end

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            state_q   <= ST_IDLE;
            col_idx   <= '0;
            pat_q     <= '0;
            cfgrows   <= '0;
            cfgcols   <= '0;
            row_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx   <= col_d;
            pat_q     <= pat_d;
            cfgrows   <= cfgrows_d;
            cfgcols   <= cfgcols_d;
            row_ready <= row_ready_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
